// File: rtl/cw_decoder_pkg.sv
// Shared types and constants for the CW (Morse) receive decoder and the
// symbol/ASCII table it shares with future sender logic.
package cw_pkg;

  localparam int SYM_W          = 7;
  localparam int DEBOUNCE_LIMIT = 14;

  localparam logic [7:0]       ASCII_SPACE = 8'h20;
  localparam logic [7:0]       ASCII_STAR  = 8'h2A;
  localparam logic [7:0]       ASCII_QMARK = 8'h3F;
  localparam logic [SYM_W-1:0] SYM_EMPTY   = 7'b0000001;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_MARK      = 3'd1,
    ST_SPACE     = 3'd2,
    ST_EMIT_CHAR = 3'd3,
    ST_GAP       = 3'd4,
    ST_EMIT_WORD = 3'd5,
    ST_LONG      = 3'd6
  } cw_state_e;

endpackage

// File: rtl/cw_decoder_morse_rom.sv
// Leading-one Morse symbol (dot=0, dash=1, first element nearest the marker)
// to ASCII. Codes outside the table map to '?'.
module morse_rom
  import cw_pkg::*;
(
  input  logic [SYM_W-1:0] i_symbol,
  output logic [7:0]       o_ascii
);

  // symbol lookup
  always_comb begin
    o_ascii = ASCII_QMARK;
    case (i_symbol)
      7'h05: o_ascii = 8'h41;  7'h18: o_ascii = 8'h42;  7'h1A: o_ascii = 8'h43;
      7'h0C: o_ascii = 8'h44;  7'h02: o_ascii = 8'h45;  7'h12: o_ascii = 8'h46;
      7'h0E: o_ascii = 8'h47;  7'h10: o_ascii = 8'h48;  7'h04: o_ascii = 8'h49;
      7'h17: o_ascii = 8'h4A;  7'h0D: o_ascii = 8'h4B;  7'h14: o_ascii = 8'h4C;
      7'h07: o_ascii = 8'h4D;  7'h06: o_ascii = 8'h4E;  7'h0F: o_ascii = 8'h4F;
      7'h16: o_ascii = 8'h50;  7'h1D: o_ascii = 8'h51;  7'h0A: o_ascii = 8'h52;
      7'h08: o_ascii = 8'h53;  7'h03: o_ascii = 8'h54;  7'h09: o_ascii = 8'h55;
      7'h11: o_ascii = 8'h56;  7'h0B: o_ascii = 8'h57;  7'h19: o_ascii = 8'h58;
      7'h1B: o_ascii = 8'h59;  7'h1C: o_ascii = 8'h5A;
      7'h3F: o_ascii = 8'h30;  7'h2F: o_ascii = 8'h31;  7'h27: o_ascii = 8'h32;
      7'h23: o_ascii = 8'h33;  7'h21: o_ascii = 8'h34;  7'h20: o_ascii = 8'h35;
      7'h30: o_ascii = 8'h36;  7'h38: o_ascii = 8'h37;  7'h3C: o_ascii = 8'h38;
      7'h3E: o_ascii = 8'h39;
      7'h55: o_ascii = 8'h2E;  7'h73: o_ascii = 8'h2C;  7'h4C: o_ascii = 8'h3F;
      7'h32: o_ascii = 8'h2F;  7'h31: o_ascii = 8'h3D;
      default: o_ascii = ASCII_QMARK;
    endcase
  end

endmodule

// File: rtl/cw_decoder.sv
// Morse receive decoder: debounced key envelope -> mark/space timing in 1 ms
// ticks -> ASCII bytes on a valid/ready stream. Define CW_ADAPTIVE_EN for speed tracking.
module cw_decoder
  import cw_pkg::*;
#(
  parameter int CLKS_PER_MS  = 76800,
  parameter int DEBOUNCE_MS  = 3,
  parameter int MAX_ELEMENTS = 6
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       key_in,
  input  logic [9:0] DotOnTime,
  output logic [7:0] char_data,
  output logic       char_valid,
  input  logic       char_ready,
  output logic       overrun,
  input  logic       clr_overrun,
  output logic [9:0] dot_est
);

  localparam int TW     = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam int DB_EFF = (DEBOUNCE_MS > DEBOUNCE_LIMIT) ? DEBOUNCE_LIMIT :
                          ((DEBOUNCE_MS < 1) ? 1 : DEBOUNCE_MS);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_MS - 1);
  localparam logic [3:0]    DB_LAST   = 4'(DB_EFF - 1);
  localparam logic [2:0]    MAX_ELEM  = 3'(MAX_ELEMENTS);

  logic            r_key_meta, r_key_s, r_key_db, r_key_db_d;
  logic [TW-1:0]   r_tick_cnt;
  logic [3:0]      r_db_cnt;
  logic [12:0]     r_dur;
  logic [SYM_W-1:0] r_symbol;
  logic [2:0]      r_elem_cnt;
  logic            r_err;
  cw_state_e       r_state;

  logic        w_tick, w_rise, w_fall, w_bit, w_emit;
  logic [9:0]  w_d;
  logic [12:0] w_t_dash, w_t_word, w_t_stuck;
  logic [13:0] w_t_stuck_w;
  logic [7:0]  w_rom_byte, w_byte;

  assign w_tick = (r_tick_cnt == TICK_LAST);
  assign w_rise = r_key_db & ~r_key_db_d;
  assign w_fall = ~r_key_db & r_key_db_d;

  // T_CHAR equals T_DASH; T_STUCK is clamped to what the saturating dur can reach
  assign w_d         = (dot_est == 10'd0) ? 10'd1 : dot_est;
  assign w_t_dash    = {2'b00, w_d, 1'b0};
  assign w_t_word    = {3'b000, w_d} + {1'b0, w_d, 2'b00};
  assign w_t_stuck_w = {1'b0, w_d, 3'b000} + {3'b000, w_d, 1'b0};
  assign w_t_stuck   = w_t_stuck_w[13] ? 13'h1FFF : w_t_stuck_w[12:0];
  assign w_bit       = (r_dur >= w_t_dash);
  assign w_emit      = (r_state == ST_EMIT_CHAR) || (r_state == ST_EMIT_WORD);

  morse_rom u_rom (.i_symbol(r_symbol), .o_ascii(w_rom_byte));

  // byte selection for the emit states
  always_comb begin
    w_byte = ASCII_SPACE;
    if (r_state == ST_EMIT_CHAR) begin
      w_byte = r_err ? ASCII_STAR : w_rom_byte;
    end else begin
      w_byte = ASCII_SPACE;
    end
  end

  // synchroniser, ms tick and debounce
  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_key_meta <= 1'b0;
      r_key_s    <= 1'b0;
      r_key_db   <= 1'b0;
      r_key_db_d <= 1'b0;
      r_tick_cnt <= '0;
      r_db_cnt   <= 4'd0;
    end else begin
      r_key_meta <= key_in;
      r_key_s    <= r_key_meta;
      r_key_db_d <= r_key_db;
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
      if (r_key_s == r_key_db) begin
        r_db_cnt <= 4'd0;
      end else if (w_tick) begin
        if (r_db_cnt == DB_LAST) begin
          r_key_db <= r_key_s;
          r_db_cnt <= 4'd0;
        end else begin
          r_db_cnt <= r_db_cnt + 4'd1;
        end
      end
    end
  end

  // duration counter and element/character FSM
  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_state    <= ST_IDLE;
      r_dur      <= 13'd0;
      r_symbol   <= SYM_EMPTY;
      r_elem_cnt <= 3'd0;
      r_err      <= 1'b0;
    end else begin
      if (w_rise || w_fall) begin
        r_dur <= 13'd0;
      end else if (w_tick && (r_dur != 13'h1FFF)) begin
        r_dur <= r_dur + 13'd1;
      end
      case (r_state)
        ST_IDLE: if (w_rise) r_state <= ST_MARK;
        ST_MARK: begin
          if (w_fall) begin
            if (r_elem_cnt == MAX_ELEM) begin
              r_err <= 1'b1;
            end else begin
              r_symbol   <= {r_symbol[SYM_W-2:0], w_bit};
              r_elem_cnt <= r_elem_cnt + 3'd1;
            end
            r_state <= ST_SPACE;
          end else if (r_dur >= w_t_stuck) begin
            r_state <= ST_LONG;
          end
        end
        ST_SPACE: begin
          if (w_rise) r_state <= ST_MARK;
          else if (w_tick && (r_dur == w_t_dash)) r_state <= ST_EMIT_CHAR;
        end
        // a rise landing on the emit clk still starts the next character
        ST_EMIT_CHAR: begin
          r_symbol   <= SYM_EMPTY;
          r_elem_cnt <= 3'd0;
          r_err      <= 1'b0;
          r_state    <= w_rise ? ST_MARK : ST_GAP;
        end
        ST_GAP: begin
          if (w_rise) r_state <= ST_MARK;
          else if (w_tick && (r_dur == w_t_word)) r_state <= ST_EMIT_WORD;
        end
        ST_EMIT_WORD: r_state <= w_rise ? ST_MARK : ST_IDLE;
        ST_LONG: begin
          r_symbol   <= SYM_EMPTY;
          r_elem_cnt <= 3'd0;
          r_err      <= 1'b0;
          if (w_fall) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // output byte register with overrun flag
  always_ff @(posedge clk) begin
    if (!rstb) begin
      char_data  <= 8'h00;
      char_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (w_emit && (!char_valid || char_ready)) begin
        char_data  <= w_byte;
        char_valid <= 1'b1;
      end else if (char_ready) begin
        char_valid <= 1'b0;
      end
      if (w_emit && char_valid && !char_ready) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

`ifdef CW_ADAPTIVE_EN
  logic [9:0]  r_dot_est;
  logic [13:0] w_est_base, w_est_add, w_est_sum;
  logic [9:0]  w_est_next;

  // exponential average; dashes contribute roughly mark*5/32
  always_comb begin
    w_est_base = {4'd0, r_dot_est} - {6'd0, r_dot_est[9:2]};
    if (w_bit) begin
      w_est_add = {4'd0, r_dur[12:3]} + {6'd0, r_dur[12:5]};
    end else begin
      w_est_add = {3'd0, r_dur[12:2]};
    end
    w_est_sum = w_est_base + w_est_add;
    if (w_est_sum > 14'd1023) begin
      w_est_next = 10'd1023;
    end else if (w_est_sum == 14'd0) begin
      w_est_next = 10'd1;
    end else begin
      w_est_next = w_est_sum[9:0];
    end
  end

  // estimate update on each classified element
  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_dot_est <= DotOnTime;
    end else if ((r_state == ST_MARK) && w_fall) begin
      r_dot_est <= w_est_next;
    end else begin
      r_dot_est <= r_dot_est;
    end
  end

  assign dot_est = r_dot_est;
`else
  assign dot_est = DotOnTime;
`endif

endmodule

// File: tb/tb_cw_decoder.sv
// Scoreboard bench for cw_decoder: stimulus keys Morse patterns and queues the
// expected bytes from a plain-text Morse table; a monitor checks each accepted byte.
module tb_cw_decoder;

  localparam int CPM  = 4;
  localparam int MAXE = 6;

  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic       key_in = 1'b0;
  logic [9:0] DotOnTime = 10'd50;
  logic [7:0] char_data;
  logic       char_valid;
  logic       char_ready;
  logic       overrun;
  logic       clr_overrun = 1'b0;
  logic [9:0] dot_est;

  logic rand_rdy = 1'b0;
  logic ready_cmd = 1'b1;
  logic rnd_bit = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   lat;
  logic [7:0] exp_q[$];
  logic [7:0] code_tbl[string];

  string codes[41] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
    ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-", "..-",
    "...-", ".--", "-..-", "-.--", "--..", "-----", ".----", "..---", "...--", "....-",
    ".....", "-....", "--...", "---..", "----.", ".-.-.-", "--..--", "..--..", "-..-.", "-...-"};
  string chars = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789.,?/=";

  cw_decoder #(.CLKS_PER_MS(CPM), .DEBOUNCE_MS(3), .MAX_ELEMENTS(MAXE)) dut (
    .clk(clk), .rstb(rstb), .key_in(key_in), .DotOnTime(DotOnTime),
    .char_data(char_data), .char_valid(char_valid), .char_ready(char_ready),
    .overrun(overrun), .clr_overrun(clr_overrun), .dot_est(dot_est)
  );

  always #5 clk = ~clk;
  assign char_ready = rand_rdy ? rnd_bit : ready_cmd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] model(input string pat);
    if (pat.len() > MAXE) return 8'h2A;
    if (code_tbl.exists(pat)) return code_tbl[pat];
    return 8'h3F;
  endfunction

  task automatic wait_ms(input int ms);
    repeat (ms * CPM) @(posedge clk);
  endtask

  task automatic key_ms(input logic lvl, input int ms);
    key_in = lvl;
    wait_ms(ms);
  endtask

  // dot = d ms, dash = 3d ms, d ms between elements, gap ms after the last
  task automatic send_pat(input string pat, input int d, input int gap);
    for (int i = 0; i < pat.len(); i++) begin
      key_ms(1'b1, (pat[i] == 8'h2D) ? 3 * d : d);
      key_ms(1'b0, (i == pat.len() - 1) ? gap : d);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rnd_bit = ($urandom_range(0, 3) != 0);
    end
  end

  // monitor: every accepted byte must match the head of the queue
  initial begin
    forever begin
      @(negedge clk);
      if (rstb && char_valid && char_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_byte: got %02h, expected none at %0t", char_data, $time);
        end else begin
          check("byte", {24'd0, char_data}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    string pat;
    int    len;
    bit    word;
    for (int i = 0; i < 41; i++) code_tbl[codes[i]] = chars[i];

    repeat (5) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, char_valid}, 32'd0);
    check("rst_data", {24'd0, char_data}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_dot_est", {22'd0, dot_est}, 32'd50);
    rstb = 1'b1;
    wait_ms(5);

    // 1: 'A' with release-to-valid latency window, then word space
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h20);
    key_ms(1'b1, 50); key_ms(1'b0, 50); key_ms(1'b1, 150);
    key_in = 1'b0;
    lat = 0;
    while (!char_valid && lat < 150 * CPM) begin
      @(posedge clk); #1; lat++;
    end
    n_cmp++;
    if (lat < 100 * CPM || lat > 106 * CPM) begin
      n_bad++;
      $display("FAIL latency_A: got %0d cycles, expected %0d..%0d", lat, 100 * CPM, 106 * CPM);
    end
    wait_ms(300);
    check("t1_drained", exp_q.size(), 32'd0);

    // 2: "SO" with 150 ms inter-character gap, single trailing space
    exp_q.push_back(8'h53); exp_q.push_back(8'h4F); exp_q.push_back(8'h20);
    send_pat("...", 50, 150);
    send_pat("---", 50, 300);
    check("t2_drained", exp_q.size(), 32'd0);

    // 3: 2 ms glitch ignored, 3 ms pulse is a dot
    key_ms(1'b1, 2); key_ms(1'b0, 300);
    #1;
    check("t3_glitch_valid", {31'd0, char_valid}, 32'd0);
    exp_q.push_back(8'h45); exp_q.push_back(8'h20);
    key_ms(1'b1, 3); key_ms(1'b0, 300);
    check("t3_drained", exp_q.size(), 32'd0);

    // 4: too many elements, and an unlisted code
    exp_q.push_back(8'h2A); exp_q.push_back(8'h20);
    send_pat(".......", 50, 300);
    exp_q.push_back(8'h3F); exp_q.push_back(8'h20);
    send_pat("..--", 50, 300);
    check("t4_drained", exp_q.size(), 32'd0);

    // 5: consumer stalled, 'T' and the space are dropped
    ready_cmd = 1'b0;
    exp_q.push_back(8'h45);
    send_pat(".", 50, 150);
    send_pat("-", 50, 300);
    #1;
    check("t5_valid", {31'd0, char_valid}, 32'd1);
    check("t5_data_held", {24'd0, char_data}, 32'h45);
    check("t5_overrun", {31'd0, overrun}, 32'd1);
    @(posedge clk); #1; clr_overrun = 1'b1;
    @(posedge clk); #1; clr_overrun = 1'b0;
    check("t5_overrun_clr", {31'd0, overrun}, 32'd0);
    ready_cmd = 1'b1;
    wait_ms(2);
    #1;
    check("t5_drained", exp_q.size(), 32'd0);
    check("t5_valid_low", {31'd0, char_valid}, 32'd0);

    // 6: stuck mark, then reset in the middle of a mark
    key_ms(1'b1, 600); key_ms(1'b0, 300);
    #1;
    check("t6_long_valid", {31'd0, char_valid}, 32'd0);
    key_ms(1'b1, 100);
    rstb = 1'b0;
    wait_ms(1);
    #1;
    check("t6_rst_valid", {31'd0, char_valid}, 32'd0);
    check("t6_rst_data", {24'd0, char_data}, 32'd0);
    check("t6_rst_overrun", {31'd0, overrun}, 32'd0);
    key_in = 1'b0;
    wait_ms(2);
    rstb = 1'b1;
    wait_ms(300);
    check("t6_drained", exp_q.size(), 32'd0);

`ifndef CW_ADAPTIVE_EN
    // random patterns at 10 ms dots with random backpressure
    DotOnTime = 10'd10;
    rand_rdy = 1'b1;
    for (int c = 0; c < 16; c++) begin
      len = $urandom_range(1, 7);
      pat = "";
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 1) == 1) pat = {pat, "-"};
        else pat = {pat, "."};
      end
      word = (c == 15) || ($urandom_range(0, 2) == 0);
      exp_q.push_back(model(pat));
      if (word) exp_q.push_back(8'h20);
      send_pat(pat, 10, word ? 70 : 30);
    end
    wait_ms(5);
    rand_rdy = 1'b0;
    ready_cmd = 1'b1;
    check("rand_drained", exp_q.size(), 32'd0);
    check("dot_est_follows", {22'd0, dot_est}, 32'd10);
`else
    // ten 30 ms dots pull the estimate down from 50
    rstb = 1'b0;
    DotOnTime = 10'd50;
    wait_ms(1);
    rstb = 1'b1;
    wait_ms(5);
    exp_q.push_back(8'h2A); exp_q.push_back(8'h20);
    send_pat("..........", 30, 300);
    n_cmp++;
    if (dot_est > 10'd33) begin
      n_bad++;
      $display("FAIL adapt_dot_est: got %0d, expected <= 33", dot_est);
    end
    check("adapt_drained", exp_q.size(), 32'd0);
`endif

    for (int k = 0; k < 1000 && exp_q.size() > 0; k++) @(posedge clk);
    check("final_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
